fetch_unit: RTL and testbench

- Instruction-fetch stage sitting directly upstream of the instruction memory.
- Owns the program counter and drives the memory word address; memory returns the instruction combinationally in the same cycle.
- Registers PC and instruction into an IF/ID output register for the decode stage.
- Handles stall, control-flow redirects (branch, jump, jump-register), halt on a self-loop jump, and misaligned-target error.

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, IF/ID register, redirects, halt
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Address,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_imm,
  input  logic        j_valid,
  input  logic [25:0] j_index,
  input  logic        jr_valid,
  input  logic [31:0] jr_target,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] issue_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] redirect_target;
  logic        redirect;
  logic        addr_bad;
  logic        self_loop;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = br_pc + 32'd4 + {{14{br_imm[15]}}, br_imm, 2'b00};
  assign j_target  = {pc_plus4[31:28], j_index, 2'b00};
  assign redirect  = jr_valid | br_taken | j_valid;

  always_comb begin
    redirect_target = j_target;
    if (jr_valid)      redirect_target = jr_target;
    else if (br_taken) redirect_target = br_target;
  end

  assign addr_bad  = (pc_q[1:0] != 2'b00) || ({2'b00, pc_q[31:2]} >= IMEM_LIMIT);
  // A j whose target is its own address can never make progress.
  assign self_loop = (Instruction[31:26] == 6'h02) &&
                     ({pc_q[31:28], Instruction[25:0], 2'b00} == pc_q);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    case (state_q)
      BOOT: begin
        state_d    = RUN;
        id_valid_d = 1'b0;
      end
      RUN: begin
        // Redirect outranks both stall and the address check: the current word is wrong-path.
        if (redirect) begin
          pc_d       = redirect_target;
          id_valid_d = 1'b0;
        end else if (addr_bad) begin
          err_d      = 1'b1;
          id_valid_d = 1'b0;
          state_d    = HALT;
        end else if (!stall) begin
          id_pc_d    = pc_q;
          id_instr_d = Instruction;
          id_valid_d = 1'b1;
          cnt_d      = cnt_q + 32'd1;
          if (self_loop) state_d = HALT;
          else           pc_d    = pc_plus4;
        end
      end
      HALT: begin
        id_valid_d = 1'b0;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      id_pc_q    <= 32'd0;
      id_instr_q <= 32'd0;
      id_valid_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Address     = pc_q;
  assign id_pc       = id_pc_q;
  assign id_instr    = id_instr_q;
  assign id_valid    = id_valid_q;
  assign halted      = (state_q == HALT);
  assign fetch_err   = err_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [15:0] br_imm;
  logic        j_valid;
  logic [25:0] j_index;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic        halted;
  logic        fetch_err;
  logic [31:0] issue_count;

  logic [31:0] mem [0:255];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .Address(Address), .Instruction(Instruction),
    .stall(stall), .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm),
    .j_valid(j_valid), .j_index(j_index), .jr_valid(jr_valid), .jr_target(jr_target),
    .id_pc(id_pc), .id_instr(id_instr), .id_valid(id_valid), .halted(halted),
    .fetch_err(fetch_err), .issue_count(issue_count)
  );

  assign Instruction = mem[Address[9:2]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; br_pc = 0; br_imm = 0;
    j_valid = 0; j_index = 0; jr_valid = 0; jr_target = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
    mem[11] = 32'h0800000B;
    idle_inputs();
    do_reset();

    check("rst_addr", Address, 32'h0);
    check("rst_valid", {31'b0, id_valid}, 32'd0);
    check("rst_idpc", id_pc, 32'h0);
    check("rst_halt", {31'b0, halted}, 32'd0);
    check("rst_err", {31'b0, fetch_err}, 32'd0);
    check("rst_cnt", issue_count, 32'd0);

    step();
    check("boot_addr", Address, 32'h0);
    check("boot_valid", {31'b0, id_valid}, 32'd0);
    step();
    check("run0_valid", {31'b0, id_valid}, 32'd1);
    check("run0_idpc", id_pc, 32'h0);
    check("run0_instr", id_instr, 32'hA000_0000);
    check("run0_addr", Address, 32'h4);
    check("run0_cnt", issue_count, 32'd1);
    step();
    check("run1_idpc", id_pc, 32'h4);
    check("run1_addr", Address, 32'h8);
    check("run1_cnt", issue_count, 32'd2);

    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", Address, 32'h8);
      check("stall_idpc", id_pc, 32'h4);
      check("stall_cnt", issue_count, 32'd2);
    end
    stall = 0;
    step();
    check("unstall_idpc", id_pc, 32'h8);
    check("unstall_cnt", issue_count, 32'd3);
    check("unstall_addr", Address, 32'hC);

    stall = 1; br_taken = 1; br_pc = 32'h10; br_imm = 16'h0001;
    step();
    idle_inputs();
    check("br_addr", Address, 32'h18);
    check("br_flush", {31'b0, id_valid}, 32'd0);
    check("br_cnt", issue_count, 32'd3);
    step();
    check("br_tgt_idpc", id_pc, 32'h18);
    check("br_tgt_valid", {31'b0, id_valid}, 32'd1);
    check("br_tgt_cnt", issue_count, 32'd4);

    br_taken = 1; br_pc = 32'h20; br_imm = 16'hFFFE;
    step();
    idle_inputs();
    check("brneg_addr", Address, 32'h1C);

    jr_valid = 1; jr_target = 32'h40; br_taken = 1; br_pc = 32'h0; br_imm = 16'h0;
    step();
    idle_inputs();
    check("jr_prio_addr", Address, 32'h40);
    step();
    check("jr_idpc", id_pc, 32'h40);
    check("jr_cnt", issue_count, 32'd5);

    j_valid = 1; j_index = 26'h00000A;
    step();
    idle_inputs();
    check("j_addr", Address, 32'h28);
    step();
    check("j_idpc", id_pc, 32'h28);
    check("j_next_addr", Address, 32'h2C);
    step();
    check("loop_idpc", id_pc, 32'h2C);
    check("loop_instr", id_instr, 32'h0800000B);
    check("loop_valid", {31'b0, id_valid}, 32'd1);
    check("loop_cnt", issue_count, 32'd7);
    check("loop_halt", {31'b0, halted}, 32'd1);
    step();
    step();
    check("halt_valid", {31'b0, id_valid}, 32'd0);
    check("halt_addr", Address, 32'h2C);
    check("halt_cnt", issue_count, 32'd7);
    check("halt_idpc", id_pc, 32'h2C);

    do_reset();
    check("rehalt_clr", {31'b0, halted}, 32'd0);
    check("restart_addr", Address, 32'h0);
    step();
    step();
    check("restart_idpc", id_pc, 32'h0);
    check("restart_cnt", issue_count, 32'd1);

    jr_valid = 1; jr_target = 32'h6;
    step();
    idle_inputs();
    check("mis_addr", Address, 32'h6);
    check("mis_err_pre", {31'b0, fetch_err}, 32'd0);
    step();
    check("mis_err", {31'b0, fetch_err}, 32'd1);
    check("mis_halt", {31'b0, halted}, 32'd1);
    check("mis_valid", {31'b0, id_valid}, 32'd0);
    check("mis_cnt", issue_count, 32'd1);

    do_reset();
    check("rst_err_clr", {31'b0, fetch_err}, 32'd0);
    step();
    jr_valid = 1; jr_target = 32'h400;
    step();
    idle_inputs();
    stall = 1;
    step();
    stall = 0;
    check("oor_err", {31'b0, fetch_err}, 32'd1);
    check("oor_halt", {31'b0, halted}, 32'd1);
    check("oor_valid", {31'b0, id_valid}, 32'd0);
    check("oor_cnt", issue_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
